lpif_tx_x2_sched: RTL and testbench

Transmit-side scheduler for the x2 asymmetric LPIF link. It arbitrates two upstream requesters: req0, the main data stream, and req1, the credit/control stream. Granted words go into one registered 75-bit beat per clk_wr that drives the TX concat stage. The block also sequences link bring-up from tx_online and generates the persistent strobe and marker userbits that the concat stage places at PHY bits 1 and 39 of each channel.

---
 rtl/lpif_tx_x2_sched.sv | 142 ++++++++++++++
 tb/tb_lpif_tx_x2_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lpif_tx_x2_sched.sv
// Transmit scheduler for the x2 asymmetric LPIF link.
// Arbitrates the main data stream (req0) against the credit/control stream (req1),
// sequences link bring-up from tx_online, and registers one 75-bit beat per clk_wr
// together with the strobe and marker userbits for the concat stage.
module lpif_tx_x2_sched #(
    parameter int DATA_WIDTH   = 75,
    parameter int STB_INTERVAL = 8,
    parameter int SYNC_BEATS   = 16,
    parameter int W0           = 3
) (
    input  logic                  clk_wr,
    input  logic                  rst_wr_n,
    input  logic                  tx_online,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic [DATA_WIDTH-1:0] tx_upstream_data,
    output logic                  tx_upstream_valid,
    output logic                  tx_stb_userbit,
    output logic [0:0]            tx_mrk_userbit,
    output logic [1:0]            sched_state
);

    typedef enum logic [1:0] {
        OFFLINE = 2'd0,
        SYNC    = 2'd1,
        RUN     = 2'd2
    } state_t;

    localparam int SBW = (STB_INTERVAL > 1) ? $clog2(STB_INTERVAL) : 1;
    localparam int SYW = $clog2(SYNC_BEATS + 1);

    state_t         state;
    state_t         state_next;
    logic [SBW-1:0] stb_cnt;
    logic           pair;
    logic [SYW-1:0] sync_cnt;
    logic [3:0]     run0;
    logic [3:0]     run0_next;
    logic           grant0;
    logic           grant1;
    logic           active;

    assign active      = (state != OFFLINE);
    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign sched_state = state;

    // Grants, req0 run-length tracking and next-state decode.
    // A falling tx_online suppresses grants in the same cycle so nothing is
    // accepted that the output register would not carry.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        run0_next  = run0;
        state_next = state;

        if (state == RUN && tx_online) begin
            if (req0_valid && (!req1_valid || run0 < 4'(W0)))
                grant0 = 1'b1;
            else if (req1_valid)
                grant1 = 1'b1;
        end

        if (state != RUN)
            run0_next = '0;
        else if (grant1 || !req1_valid)
            run0_next = '0;
        else if (grant0)
            run0_next = run0 + 4'd1;

        if (!tx_online) begin
            state_next = OFFLINE;
        end else begin
            case (state)
                OFFLINE: state_next = SYNC;
                SYNC:    if (sync_cnt == SYW'(SYNC_BEATS - 1)) state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = OFFLINE;
            endcase
        end
    end

    // FSM state and arbiter run counter.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state <= OFFLINE;
            run0  <= '0;
        end else begin
            state <= state_next;
            run0  <= run0_next;
        end
    end

    // Counts sync beats while in SYNC; idle elsewhere.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n)
            sync_cnt <= '0;
        else if (state == SYNC)
            sync_cnt <= sync_cnt + SYW'(1);
        else
            sync_cnt <= '0;
    end

    // Strobe period counter and marker pair toggle, running on every active beat.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            stb_cnt <= '0;
            pair    <= 1'b0;
        end else if (!active) begin
            stb_cnt <= '0;
            pair    <= 1'b0;
        end else begin
            stb_cnt <= (stb_cnt == SBW'(STB_INTERVAL - 1)) ? '0 : stb_cnt + SBW'(1);
            pair    <= ~pair;
        end
    end

    // Output beat register: granted word or idle beat, with aligned userbits.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            tx_upstream_data  <= '0;
            tx_upstream_valid <= 1'b0;
            tx_stb_userbit    <= 1'b0;
            tx_mrk_userbit    <= '0;
        end else if (!active) begin
            tx_upstream_data  <= '0;
            tx_upstream_valid <= 1'b0;
            tx_stb_userbit    <= 1'b0;
            tx_mrk_userbit    <= '0;
        end else begin
            tx_upstream_data  <= grant0 ? req0_data : (grant1 ? req1_data : '0);
            tx_upstream_valid <= grant0 | grant1;
            tx_stb_userbit    <= (stb_cnt == '0);
            tx_mrk_userbit    <= pair;
        end
    end

endmodule

// File: tb/tb_lpif_tx_x2_sched.sv
// Directed self-checking bench for lpif_tx_x2_sched.
module tb_lpif_tx_x2_sched;

    localparam int DW = 75;

    logic          clk_wr     = 1'b0;
    logic          rst_wr_n   = 1'b0;
    logic          tx_online  = 1'b0;
    logic          req0_valid = 1'b1;
    logic [DW-1:0] req0_data  = '0;
    logic          req1_valid = 1'b0;
    logic [DW-1:0] req1_data  = '0;
    logic          req0_ready;
    logic          req1_ready;
    logic [DW-1:0] tx_upstream_data;
    logic          tx_upstream_valid;
    logic          tx_stb_userbit;
    logic [0:0]    tx_mrk_userbit;
    logic [1:0]    sched_state;

    int passed = 0;
    int total  = 0;
    int beat   = 0;

    logic [DW-1:0] d0;
    logic [DW-1:0] d1;

    // Both valid for 8 cycles, then req1 drops for one cycle after 2 req0 grants.
    bit tbl_r1v [15] = '{1,1,1,1,1,1,1,1, 1,1,0,1,1,1,1};
    bit tbl_g1  [15] = '{0,0,0,1,0,0,0,1, 0,0,0,0,0,0,1};

    always #5 clk_wr = ~clk_wr;

    lpif_tx_x2_sched #(
        .DATA_WIDTH  (DW),
        .STB_INTERVAL(8),
        .SYNC_BEATS  (16),
        .W0          (3)
    ) dut (
        .clk_wr           (clk_wr),
        .rst_wr_n         (rst_wr_n),
        .tx_online        (tx_online),
        .req0_valid       (req0_valid),
        .req0_data        (req0_data),
        .req0_ready       (req0_ready),
        .req1_valid       (req1_valid),
        .req1_data        (req1_data),
        .req1_ready       (req1_ready),
        .tx_upstream_data (tx_upstream_data),
        .tx_upstream_valid(tx_upstream_valid),
        .tx_stb_userbit   (tx_stb_userbit),
        .tx_mrk_userbit   (tx_mrk_userbit),
        .sched_state      (sched_state)
    );

    task automatic tick();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Checks one active beat; strobe every 8th beat, marker on odd beats.
    task automatic check_beat(input logic [DW-1:0] exp_d, input logic exp_v);
        chkd("beat_data", tx_upstream_data, exp_d);
        chk1("beat_valid", tx_upstream_valid, exp_v);
        chk1("beat_stb", tx_stb_userbit, (beat % 8) == 0);
        chk1("beat_mrk", tx_mrk_userbit[0], 1'(beat % 2));
        beat = beat + 1;
    endtask

    task automatic check_zero(input string tag);
        chkd({tag, "_data"}, tx_upstream_data, '0);
        chk1({tag, "_valid"}, tx_upstream_valid, 1'b0);
        chk1({tag, "_stb"}, tx_stb_userbit, 1'b0);
        chk1({tag, "_mrk"}, tx_mrk_userbit[0], 1'b0);
    endtask

    // Caller holds tx_online=1 and req0_valid=1; expects 16 idle sync beats.
    task automatic run_sync();
        tick();
        chk2("sync_entry_state", sched_state, 2'd1);
        chk1("sync_entry_ready0", req0_ready, 1'b0);
        check_zero("sync_entry");
        beat = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check_beat('0, 1'b0);
            chk2("sync_state", sched_state, (i == 15) ? 2'd2 : 2'd1);
            chk1("sync_ready0", req0_ready, i == 15);
            chk1("sync_ready1", req1_ready, 1'b0);
        end
    endtask

    initial begin
        // Reset state, with req0 already requesting.
        #12;
        check_zero("reset");
        chk1("reset_ready0", req0_ready, 1'b0);
        chk1("reset_ready1", req1_ready, 1'b0);
        chk2("reset_state", sched_state, 2'd0);
        rst_wr_n = 1'b1;

        tick();
        chk2("offline_state", sched_state, 2'd0);
        chk1("offline_ready0", req0_ready, 1'b0);
        check_zero("offline");

        // Bring-up, then 10 back-to-back req0 words.
        tx_online = 1'b1;
        req0_data = DW'(1);
        run_sync();
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_beat(DW'(k), 1'b1);
            if (k < 10) req0_data = DW'(k + 1);
            else        req0_valid = 1'b0;
            #1;
            chk1("burst_ready0", req0_ready, k < 10);
        end
        tick();
        check_beat('0, 1'b0);

        // Both requesters: W0=3 weighting, then req1 drop clears run0.
        d0 = DW'(12'h100);
        d1 = DW'(12'h200);
        req0_valid = 1'b1;
        req0_data  = d0;
        req1_data  = d1;
        for (int c = 0; c < 15; c++) begin
            req1_valid = tbl_r1v[c];
            #1;
            chk1("arb_ready0", req0_ready, !tbl_g1[c]);
            chk1("arb_ready1", req1_ready, tbl_g1[c]);
            tick();
            check_beat(tbl_g1[c] ? d1 : d0, 1'b1);
            if (tbl_g1[c]) d1 = d1 + DW'(1);
            else           d0 = d0 + DW'(1);
            req0_data = d0;
            req1_data = d1;
        end

        // tx_online falls with both valid: no grant, one last pattern beat, then zeros.
        tx_online = 1'b0;
        #1;
        chk1("drop_ready0", req0_ready, 1'b0);
        chk1("drop_ready1", req1_ready, 1'b0);
        tick();
        chk2("drop_state", sched_state, 2'd0);
        check_beat('0, 1'b0);
        tick();
        check_zero("drop_after");
        chk1("drop_after_ready0", req0_ready, 1'b0);

        // Re-raise: full sync again, one word, then async reset mid-cycle.
        tx_online  = 1'b1;
        req1_valid = 1'b0;
        req0_data  = DW'(7);
        run_sync();
        tick();
        check_beat(DW'(7), 1'b1);
        req0_data = DW'(8);
        #2;
        rst_wr_n = 1'b0;
        #1;
        check_zero("async_rst");
        chk1("async_rst_ready0", req0_ready, 1'b0);
        chk2("async_rst_state", sched_state, 2'd0);
        #10;
        rst_wr_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
